// File: rtl/ff_pkg.sv
// ff_pkg: shared pipeline defaults and the occupancy-width helper used by every pipeline user.
package ff_pkg;
  localparam int FF_WIDTH = 8;
  localparam int FF_DEPTH = 2;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 2);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid bit plus payload register; loads when empty or when the next slot frees up.
module pipe_stage
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_WIDTH
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             flush,
  input  logic             i_valid,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_v;
  logic [WIDTH-1:0] r_d;
  logic             w_load;
  assign w_load  = ~r_v | i_ready;
  assign o_valid = r_v;
  assign o_data  = r_d;
  always_ff @(posedge clk or negedge r_n)
    if (!r_n) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else begin
      r_v <= flush ? 1'b0 : (w_load ? i_valid : r_v);
      if (w_load & i_valid) r_d <= i_data;
    end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready pipeline with flush and occupancy count.
// Define PIPE_SKID_EN for a one-entry skid ahead of stage 0 that registers in_ready.
module pipe_reg_chain
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_WIDTH,
  parameter int DEPTH = FF_DEPTH
) (
  input  logic                     clk,
  input  logic                     r_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);
  localparam int OCC_W = occ_w(DEPTH);
  logic [DEPTH:0]              w_rdy;
  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_d;
  logic [DEPTH:0]              w_vc;
  logic [DEPTH:0][WIDTH-1:0]   w_dc;
  logic                        w_vin;
  logic [WIDTH-1:0]            w_din;
  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic [OCC_W-1:0]            r_occ;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign w_rdy[DEPTH] = out_ready;
  assign w_vc = {w_v, w_vin};
  assign w_dc = {w_d, w_din};
  assign out_valid = w_vc[DEPTH];
  assign out_data  = w_dc[DEPTH];
  assign occupancy = r_occ;
`ifdef PIPE_SKID_EN
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_d;
  assign in_ready = ~r_skid_v & ~flush;
  assign w_vin    = r_skid_v | w_in_xfer;
  assign w_din    = r_skid_v ? r_skid_d : in_data;
  // A parked beat always goes to stage 0 before any new input can be accepted.
  always_ff @(posedge clk or negedge r_n)
    if (!r_n) begin
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else begin
      r_skid_v <= ~flush & ~w_rdy[0] & w_vin;
      if (w_in_xfer & ~w_rdy[0]) r_skid_d <= in_data;
    end
`else
  assign in_ready = w_rdy[0] & ~flush;
  assign w_vin    = w_in_xfer;
  assign w_din    = in_data;
`endif
  // Ready is formed from the valid bits directly so bubbles anywhere downstream free a stage.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign w_rdy[i] = out_ready | ~&w_v[DEPTH-1:i];
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .r_n     (r_n),
      .flush   (flush),
      .i_valid (w_vc[i]),
      .i_ready (w_rdy[i+1]),
      .i_data  (w_dc[i]),
      .o_valid (w_v[i]),
      .o_data  (w_d[i])
    );
  end
  always_ff @(posedge clk or negedge r_n)
    if (!r_n) r_occ <= '0;
    else r_occ <= flush ? '0 : r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and randomized checks of pipe_reg_chain against a queue-based model.
module tb_pipe_reg_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk, r_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [$clog2(DEPTH+2)-1:0] occupancy;
  int checks = 0;
  int errors = 0;
  typedef struct { logic [WIDTH-1:0] d; int t; } ent_t;
  ent_t q[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .r_n(r_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Model: entries in acceptance order, each tagged with the cycle it was accepted in.
  initial begin : compare
    int n;
    bit e_rdy, e_ov;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!r_n) q.delete();
      else begin
        e_rdy = !flush && (SKID ? q.size() <= DEPTH : (out_ready || q.size() < DEPTH));
        e_ov  = q.size() > 0 && (n - q[0].t) >= DEPTH;
        chk("m_in_ready", int'(in_ready), int'(e_rdy));
        chk("m_out_valid", int'(out_valid), int'(e_ov));
        chk("m_occupancy", int'(occupancy), q.size());
        if (e_ov) chk("m_out_data", int'(out_data), int'(q[0].d));
        if (flush) q.delete();
        else begin
          if (e_ov && out_ready) void'(q.pop_front());
          if (in_valid && e_rdy) q.push_back('{in_data, n});
        end
      end
    end
  end

  initial begin : drive
    int acc, lat, nexp;
    bit pend;
    r_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3 r_n = 1'b0;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_occupancy", int'(occupancy), 0);
    repeat (2) cycle();
    r_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    cycle();
    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      cycle();
      if (i >= 3) begin
        chk("stream_out_valid", int'(out_valid), 1);
        chk("stream_out_data", int'(out_data), i - 2);
        chk("stream_occupancy", int'(occupancy), 3);
      end
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("stream_drained", int'(occupancy), 0);
    // backpressure
    out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hA0 + acc);
      @(negedge clk);
      if (in_ready) acc++;
      cycle();
    end
    in_valid = 1'b0;
    nexp = SKID ? DEPTH + 1 : DEPTH;
    chk("bp_accepted", acc, nexp);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_data", int'(out_data), 8'hA0);
    chk("bp_occupancy", int'(occupancy), nexp);
    out_ready = 1'b1;
    for (int k = 0; k < nexp; k++) begin
      chk("bp_drain_data", int'(out_data), 8'hA0 + k);
      cycle();
    end
    chk("bp_drained", int'(out_valid), 0);
    // simultaneous in/out on a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h30 + i);
      cycle();
    end
    chk("sim_full", int'(occupancy), 3);
    out_ready = 1'b1;
    in_data = 8'h33;
    @(negedge clk);
    chk("sim_in_ready", int'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
    chk("sim_occupancy", int'(occupancy), 3);
    chk("sim_out_data", int'(out_data), 8'h31);
    repeat (4) cycle();
    // flush
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h40 + i);
      cycle();
    end
    in_data = 8'h99;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 0);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_occupancy", int'(occupancy), 0);
    in_valid = 1'b1;
    in_data = 8'h55;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_flush_in_ready", int'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("flush_latency", lat, 3);
    chk("flush_out_data", int'(out_data), 8'h55);
    cycle();
    // asynchronous reset with two entries held
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hB0 + i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("pre_reset_out_valid", int'(out_valid), 1);
    r_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_out_data", int'(out_data), 0);
    chk("async_occupancy", int'(occupancy), 0);
    cycle();
    r_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    cycle();
    // random traffic; a refused beat is held unchanged until taken
    pend = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < ((c / 1000) % 2 == 0 ? 6 : 3));
      flush = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      pend = in_valid && !in_ready;
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("final_empty", int'(occupancy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
